// File: rtl/byte_data_memory.sv
// byte_data_memory: byte-addressed 64-bit-word data memory with RV64 sub-word loads/stores
//
// Ports
//   clk          : system clock, all state updates on its falling edge
//   rst_n        : asynchronous active-low reset
//   MemRead      : load request, sampled at the negedge
//   MemWrite     : store request, sampled at the negedge
//   address      : byte address
//   funct3       : access type (B/H/W/D, BU/HU/WU); stores use funct3[1:0]
//   write_data   : store data, low bytes used
//   read_data    : extended load result, holds between loads
//   rd_valid     : one-cycle pulse per completed (accepted) load
//   busy         : post-reset clear sweep in progress, requests dropped
//   misaligned   : last accepted request was misaligned (one cycle)
//   out_of_range : last accepted request was out of range (one cycle)
module byte_data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [63:0] address,
    input  logic [2:0]  funct3,
    input  logic [63:0] write_data,
    output logic [63:0] read_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        misaligned,
    output logic        out_of_range
);
    typedef enum logic [1:0] {RESET, CLEAR, READY} state_t;

    state_t           state, state_nx;
    logic [IDX_W-1:0] clr_idx;
    logic [63:0]      mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic [2:0]       off;
    logic [1:0]       sz;
    logic             accept, mis, oor, fault, signed_ld;
    logic [7:0]       size_lanes, lanes;
    logic [63:0]      bit_mask, wr_shift, rd_word, rd_shift, load_val;

    assign idx       = address[IDX_W+2:3];
    assign off       = address[2:0];
    assign sz        = funct3[1:0];
    assign signed_ld = ~funct3[2];
    assign accept    = (state == READY) && (MemRead || MemWrite);

    // Any address bit above the array span means out of range; no aliasing.
    assign oor   = |address[63:IDX_W+3];
    assign mis   = (sz == 2'd1 && off[0]) || (sz == 2'd2 && off[1:0] != 2'd0) ||
                   (sz == 2'd3 && off != 3'd0) || (MemRead && funct3 == 3'b111);
    assign fault = mis || oor;

    assign size_lanes = sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF;
    assign lanes      = size_lanes << off;
    assign wr_shift   = write_data << {off, 3'b000};
    assign rd_word    = mem[idx];
    assign rd_shift   = rd_word >> {off, 3'b000};

    always_comb begin
        bit_mask = '0;
        for (int i = 0; i < 8; i++) bit_mask[8*i +: 8] = {8{lanes[i]}};
    end

    assign load_val = sz == 2'd0 ? {{56{signed_ld & rd_shift[7]}},  rd_shift[7:0]}  :
                      sz == 2'd1 ? {{48{signed_ld & rd_shift[15]}}, rd_shift[15:0]} :
                      sz == 2'd2 ? {{32{signed_ld & rd_shift[31]}}, rd_shift[31:0]} :
                                   rd_shift;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RESET;
            clr_idx <= '0;
        end else begin
            state   <= state_nx;
            clr_idx <= state == READY ? clr_idx : clr_idx + 1'b1;
        end
    end

    // RESET already clears index 0 on its first negedge after release.
    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        if (state == READY) busy = 1'b0;
        else state_nx = clr_idx == IDX_W'(DEPTH_WORDS - 1) ? READY : CLEAR;
    end

    // The array has no reset; the sweep clears it. Stores merge into the
    // pre-write word so untouched lanes keep their value.
    always_ff @(negedge clk) begin
        if (state != READY) mem[clr_idx] <= '0;
        else if (accept && MemWrite && !fault) mem[idx] <= (rd_word & ~bit_mask) | (wr_shift & bit_mask);
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data    <= '0;
            rd_valid     <= 1'b0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            rd_valid     <= accept && MemRead;
            misaligned   <= accept && mis;
            out_of_range <= accept && oor;
            if (accept && MemRead) read_data <= fault ? '0 : load_val;
        end
    end
endmodule

// File: tb/tb_byte_data_memory.sv
// tb_byte_data_memory: directed vector bench for byte_data_memory
module tb_byte_data_memory;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [63:0] address = '0;
    logic [2:0]  funct3 = '0;
    logic [63:0] write_data = '0;
    logic [63:0] read_data;
    logic        rd_valid, busy, misaligned, out_of_range;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wd;
        logic [63:0] rdata;
        logic        rv;
        logic        mis;
        logic        oor;
    } vec_t;

    vec_t vecs[$];

    byte_data_memory #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .address(address), .funct3(funct3), .write_data(write_data),
        .read_data(read_data), .rd_valid(rd_valid), .busy(busy),
        .misaligned(misaligned), .out_of_range(out_of_range)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int n, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, n, got, exp);
        end
    endtask

    task automatic add(input logic rd, input logic wr, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [63:0] exp, input logic rv,
                       input logic mis, input logic oor);
        vecs.push_back('{rd, wr, f3, a, wd, exp, rv, mis, oor});
    endtask

    // Drive one request, let it be sampled at the next negedge, return just after it.
    task automatic apply(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
        MemRead = rd; MemWrite = wr; funct3 = f3; address = a; write_data = wd;
        @(negedge clk);
        #1;
    endtask

    // Counts negedges from release until busy drops; a load at step 5 must be dropped.
    task automatic sweep(input int tag);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            MemRead = (i == 5); MemWrite = 1'b0; funct3 = 3'd3; address = 64'h10;
            @(negedge clk);
            #1;
            if (i == 5) chk("sweep_drop_rv", tag, {63'd0, rd_valid}, 64'd0);
            if (!busy) begin
                n = i;
                break;
            end
        end
        MemRead = 1'b0;
        chk("sweep_len", tag, 64'(n), 64'(DEPTH));
    endtask

    initial begin
        add(1,0,3,64'h78, 0,                      64'h0,                1,0,0);
        add(0,1,3,64'h10, 64'h8877665544332211,   64'h0,                0,0,0);
        add(1,0,0,64'h17, 0,                      64'hFFFFFFFFFFFFFF88, 1,0,0);
        add(1,0,4,64'h17, 0,                      64'h88,               1,0,0);
        add(1,0,1,64'h12, 0,                      64'h4433,             1,0,0);
        add(1,0,1,64'h16, 0,                      64'hFFFFFFFFFFFF8877, 1,0,0);
        add(1,0,5,64'h16, 0,                      64'h8877,             1,0,0);
        add(1,0,6,64'h14, 0,                      64'h88776655,         1,0,0);
        add(1,0,2,64'h14, 0,                      64'hFFFFFFFF88776655, 1,0,0);
        add(0,1,3,64'h20, 0,                      64'hFFFFFFFF88776655, 0,0,0);
        add(0,1,0,64'h23, 64'h123456789ABCDEAB,   64'hFFFFFFFF88776655, 0,0,0);
        add(0,1,1,64'h26, 64'hFFFFFFFFFFFFCDEF,   64'hFFFFFFFF88776655, 0,0,0);
        add(1,0,3,64'h20, 0,                      64'hCDEF0000AB000000, 1,0,0);
        add(1,0,2,64'h22, 0,                      64'h0,                1,1,0);
        add(0,1,3,64'h80, 64'hFFFFFFFFFFFFFFFF,   64'h0,                0,0,1);
        add(0,1,3,64'h800,64'hFFFFFFFFFFFFFFFF,   64'h0,                0,0,1);
        add(1,0,3,64'h0,  0,                      64'h0,                1,0,0);
        add(1,0,3,64'h10, 0,                      64'h8877665544332211, 1,0,0);
        add(1,0,7,64'h10, 0,                      64'h0,                1,1,0);
        add(0,0,0,64'h0,  0,                      64'h0,                0,0,0);
        add(0,1,3,64'h20, 64'h1111,               64'h0,                0,0,0);
        add(1,1,3,64'h20, 64'h2222,               64'h1111,             1,0,0);
        add(1,0,3,64'h20, 0,                      64'h2222,             1,0,0);
        add(0,1,1,64'h21, 64'hFFFF,               64'h2222,             0,1,0);
        add(1,0,3,64'h20, 0,                      64'h2222,             1,0,0);
        add(0,1,3,64'h78, 64'hDEADBEEF,           64'h2222,             0,0,0);
        add(1,0,3,64'h78, 0,                      64'hDEADBEEF,         1,0,0);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdata", 0, read_data, 64'h0);
        chk("rst_rv",    0, {63'd0, rd_valid}, 64'd0);
        chk("rst_busy",  0, {63'd0, busy}, 64'd1);
        chk("rst_mis",   0, {63'd0, misaligned}, 64'd0);
        chk("rst_oor",   0, {63'd0, out_of_range}, 64'd0);

        @(posedge clk);
        rst_n = 1'b1;
        sweep(0);

        foreach (vecs[i]) begin
            apply(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wd);
            chk("rdata", i, read_data, vecs[i].rdata);
            chk("rv",    i, {63'd0, rd_valid}, {63'd0, vecs[i].rv});
            chk("mis",   i, {63'd0, misaligned}, {63'd0, vecs[i].mis});
            chk("oor",   i, {63'd0, out_of_range}, {63'd0, vecs[i].oor});
        end

        apply(1, 0, 3, 64'h10, 0);
        chk("mid_ld_rv",    0, {63'd0, rd_valid}, 64'd1);
        chk("mid_ld_rdata", 0, read_data, 64'h8877665544332211);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rdata", 0, read_data, 64'h0);
        chk("mid_rst_rv",    0, {63'd0, rd_valid}, 64'd0);
        chk("mid_rst_busy",  0, {63'd0, busy}, 64'd1);
        MemRead = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        rst_n = 1'b1;
        sweep(1);

        apply(1, 0, 3, 64'h10, 0);
        chk("post_ld_rv",    0, {63'd0, rd_valid}, 64'd1);
        chk("post_ld_rdata", 0, read_data, 64'h0);
        apply(1, 0, 3, 64'h78, 0);
        chk("post_ld_last",  0, read_data, 64'h0);
        apply(0, 0, 0, 64'h0, 0);
        chk("idle_rv",       0, {63'd0, rd_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
